// File: rtl/simple_algo_pkg.sv
// Shared state encoding, default sizing and a width helper for the simple_algo
// stream driver and its lane packers.
package simple_algo_pkg;

    localparam int DEF_LANES   = 4;
    localparam int DEF_W       = 11;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PUSH    = 2'd1,
        START   = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rtl_simple_algo_stream_driver_if.sv
// Bundle of the driver's stream, FIFO, adder-block and result handshakes;
// master is the driver side, slave is the environment side.
interface rtl_simple_algo_stream_driver_if
    import simple_algo_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int W     = DEF_W
);
    logic               s_valid;
    logic               s_ready;
    logic [W-1:0]       s_a;
    logic [W-1:0]       s_b;
    logic [LANES*W-1:0] a_dout;
    logic               a_write;
    logic               a_full_n;
    logic [LANES*W-1:0] b_dout;
    logic               b_write;
    logic               b_full_n;
    logic               blk_start;
    logic               blk_continue;
    logic               blk_done;
    logic [W-1:0]       z1, z2, z3, z4;
    logic               r_valid;
    logic               r_ready;
    logic [W-1:0]       r_data;
    logic               r_last;
    logic               busy;
    logic               err_timeout;

    modport master (
        input  s_valid, s_a, s_b, a_full_n, b_full_n, blk_done,
               z1, z2, z3, z4, r_ready,
        output s_ready, a_dout, a_write, b_dout, b_write, blk_start,
               blk_continue, r_valid, r_data, r_last, busy, err_timeout
    );

    modport slave (
        output s_valid, s_a, s_b, a_full_n, b_full_n, blk_done,
               z1, z2, z3, z4, r_ready,
        input  s_ready, a_dout, a_write, b_dout, b_write, blk_start,
               blk_continue, r_valid, r_data, r_last, busy, err_timeout
    );
endinterface

// File: rtl/lane_packer.sv
// Packs LANES consecutive W-bit samples into one word, lane 0 in the low bits;
// `last` flags the load that completes the word.
module lane_packer
    import simple_algo_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int W     = DEF_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [W-1:0]       din,
    output logic [LANES*W-1:0] word,
    output logic               last
);
    localparam int CW = cnt_w(LANES);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LANES*W-1:0] word_q, word_d;

    assign last = load && (cnt_q == CW'(LANES - 1));
    assign word = word_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        cnt_d  = cnt_q;
        word_d = word_q;
        if (load) begin
            word_d[int'(cnt_q) * W +: W] = din;
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/rtl_simple_algo_stream_driver.sv
// Collects four A/B beats, pushes the packed words to two FIFOs, runs the adder
// block through its ap_start/ap_done handshake and streams the four sums out.
module rtl_simple_algo_stream_driver
    import simple_algo_pkg::*;
#(
    parameter int LANES   = DEF_LANES,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic ap_clk,
    input  logic ap_rst,
    input  logic ap_ce,
    rtl_simple_algo_stream_driver_if.master bus
);
    localparam int TW = cnt_w(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic             a_sent_q, a_sent_d;
    logic             b_sent_q, b_sent_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [3:0][W-1:0] res_q, res_d;
    logic [1:0]       r_idx_q, r_idx_d;
    logic             err_q, err_d;
    logic             run, beat, a_last, b_last;

    // Strobes are also masked by reset so a word caught mid-flight is never written.
    assign run         = ap_ce && !ap_rst;
    assign bus.s_ready = run && (state_q == COLLECT);
    assign beat        = bus.s_valid && bus.s_ready;

    assign bus.r_data      = res_q[r_idx_q];
    assign bus.busy        = !ap_rst && (state_q != COLLECT);
    assign bus.err_timeout = err_q;

    lane_packer #(.LANES(LANES), .W(W)) u_pack_a (
        .clk(ap_clk), .rst(ap_rst), .load(beat), .din(bus.s_a),
        .word(bus.a_dout), .last(a_last)
    );

    lane_packer #(.LANES(LANES), .W(W)) u_pack_b (
        .clk(ap_clk), .rst(ap_rst), .load(beat), .din(bus.s_b),
        .word(bus.b_dout), .last(b_last)
    );

    always_comb begin
        state_d          = state_q;
        a_sent_d         = a_sent_q;
        b_sent_d         = b_sent_q;
        tmo_d            = tmo_q;
        res_d            = res_q;
        r_idx_d          = r_idx_q;
        err_d            = err_q;
        bus.a_write      = 1'b0;
        bus.b_write      = 1'b0;
        bus.blk_start    = 1'b0;
        bus.blk_continue = 1'b0;
        bus.r_valid      = 1'b0;
        bus.r_last       = 1'b0;
        case (state_q)
            COLLECT: if (a_last && b_last) state_d = PUSH;
            PUSH: begin
                bus.a_write = run && bus.a_full_n && !a_sent_q;
                bus.b_write = run && bus.b_full_n && !b_sent_q;
                a_sent_d    = a_sent_q || bus.a_write;
                b_sent_d    = b_sent_q || bus.b_write;
                if (a_sent_d && b_sent_d) begin
                    a_sent_d = 1'b0;
                    b_sent_d = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                bus.blk_start = !ap_rst;
                tmo_d         = tmo_q + 1'b1;
                if (bus.blk_done) begin
                    bus.blk_continue = run;
                    res_d   = {bus.z4, bus.z3, bus.z2, bus.z1};
                    tmo_d   = '0;
                    state_d = DRAIN;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = COLLECT;
                end
            end
            DRAIN: begin
                bus.r_valid = !ap_rst;
                bus.r_last  = !ap_rst && (r_idx_q == 2'd3);
                if (bus.r_ready) begin
                    r_idx_d = r_idx_q + 2'd1;
                    if (r_idx_q == 2'd3) state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= COLLECT;
            a_sent_q <= 1'b0;
            b_sent_q <= 1'b0;
            tmo_q    <= '0;
            // NOTE: the result registers are reset because r_data must read zero after reset.
            res_q    <= '0;
            r_idx_q  <= '0;
            err_q    <= 1'b0;
        end else if (ap_ce) begin
            state_q  <= state_d;
            a_sent_q <= a_sent_d;
            b_sent_q <= b_sent_d;
            tmo_q    <= tmo_d;
            res_q    <= res_d;
            r_idx_q  <= r_idx_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_rtl_simple_algo_stream_driver.sv
// Directed bench for the stream driver with a FIFO sink and a two-cycle adder model.
module tb_rtl_simple_algo_stream_driver;
    localparam int LANES   = 4;
    localparam int W       = 11;
    localparam int TIMEOUT = 255;

    typedef logic [3:0][W-1:0] quad_t;

    logic ap_clk = 1'b0;
    logic ap_rst;
    logic ap_ce;
    int   n_vec = 0;
    int   n_err = 0;

    rtl_simple_algo_stream_driver_if #(.LANES(LANES), .W(W)) bus ();

    rtl_simple_algo_stream_driver #(.LANES(LANES), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .bus(bus)
    );

    always #5 ap_clk = ~ap_clk;

    // FIFO sinks and adder block: done rises two cycles into blk_start.
    logic [LANES*W-1:0] fifo_a, fifo_b;
    int   a_wr_cnt  = 0;
    int   b_wr_cnt  = 0;
    int   adder_cnt = 0;
    logic adder_en;

    always @(posedge ap_clk) begin
        if (bus.a_write) begin
            fifo_a   <= bus.a_dout;
            a_wr_cnt <= a_wr_cnt + 1;
        end
        if (bus.b_write) begin
            fifo_b   <= bus.b_dout;
            b_wr_cnt <= b_wr_cnt + 1;
        end
        if (ap_rst || !adder_en || bus.blk_continue) begin
            adder_cnt    <= 0;
            bus.blk_done <= 1'b0;
        end else if (bus.blk_start && !bus.blk_done) begin
            adder_cnt <= adder_cnt + 1;
            if (adder_cnt == 1) bus.blk_done <= 1'b1;
        end
    end

    assign bus.z1 = W'(fifo_a[0*W +: W] + fifo_b[0*W +: W]);
    assign bus.z2 = W'(fifo_a[1*W +: W] + fifo_b[1*W +: W]);
    assign bus.z3 = W'(fifo_a[2*W +: W] + fifo_b[2*W +: W]);
    assign bus.z4 = W'(fifo_a[3*W +: W] + fifo_b[3*W +: W]);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge ap_clk);
        #1;
    endtask

    function automatic quad_t quad(input int l0, input int l1, input int l2, input int l3);
        quad_t q;
        q[0] = W'(l0);
        q[1] = W'(l1);
        q[2] = W'(l2);
        q[3] = W'(l3);
        return q;
    endfunction

    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b);
        int g = 0;
        bus.s_valid = 1'b1;
        bus.s_a     = a;
        bus.s_b     = b;
        while (!bus.s_ready && g < 100) begin
            step();
            g++;
        end
        check("s_ready_wait", 64'(bus.s_ready), 64'(1));
        step();
        bus.s_valid = 1'b0;
    endtask

    task automatic send_group(input quad_t a, input quad_t b);
        for (int i = 0; i < 4; i++) send_beat(a[i], b[i]);
    endtask

    task automatic drain4(input quad_t exp, input int stall_lane, input int stall);
        int g = 0;
        bus.r_ready = 1'b0;
        while (!bus.r_valid && g < 400) begin
            step();
            g++;
        end
        for (int i = 0; i < 4; i++) begin
            if (i == stall_lane) begin
                for (int s = 0; s < stall; s++) begin
                    check("r_stall_data", 64'(bus.r_data), 64'(exp[i]));
                    step();
                end
            end
            check($sformatf("r_valid%0d", i), 64'(bus.r_valid), 64'(1));
            check($sformatf("r_data%0d", i), 64'(bus.r_data), 64'(exp[i]));
            check($sformatf("r_last%0d", i), 64'(bus.r_last), 64'(i == 3));
            bus.r_ready = 1'b1;
            step();
            bus.r_ready = 1'b0;
        end
        check("drain_idle", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, b0, lat, n;
        ap_rst       = 1'b1;
        ap_ce        = 1'b1;
        adder_en     = 1'b1;
        bus.s_valid  = 1'b0;
        bus.s_a      = '0;
        bus.s_b      = '0;
        bus.a_full_n = 1'b1;
        bus.b_full_n = 1'b1;
        bus.r_ready  = 1'b0;
        repeat (3) step();

        check("rst_s_ready", 64'(bus.s_ready), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_err", 64'(bus.err_timeout), 64'(0));
        check("rst_a_dout", 64'(bus.a_dout), 64'(0));
        check("rst_r_valid", 64'(bus.r_valid), 64'(0));
        ap_rst = 1'b0;
        step();
        check("idle_s_ready", 64'(bus.s_ready), 64'(1));
        ap_ce = 1'b0;
        #1;
        check("ce_low_s_ready", 64'(bus.s_ready), 64'(0));
        ap_ce = 1'b1;
        #1;

        // Basic group, packing and latency.
        a0 = a_wr_cnt;
        b0 = b_wr_cnt;
        send_group(quad(1, 2, 3, 4), quad(10, 20, 30, 40));
        check("t1_a_dout", 64'(bus.a_dout), 64'h800C01001);
        check("t1_b_dout", 64'(bus.b_dout), 64'h500780A00A);
        check("t1_a_write", 64'(bus.a_write), 64'(1));
        check("t1_b_write", 64'(bus.b_write), 64'(1));
        check("t1_s_ready", 64'(bus.s_ready), 64'(0));
        lat = 0;
        while (!bus.r_valid && lat < 50) begin
            step();
            lat++;
            if (lat == 1) check("t1_blk_start", 64'(bus.blk_start), 64'(1));
        end
        check("t1_latency", 64'(lat), 64'(4));
        drain4(quad(11, 22, 33, 44), 4, 0);
        check("t1_a_writes", 64'(a_wr_cnt - a0), 64'(1));
        check("t1_b_writes", 64'(b_wr_cnt - b0), 64'(1));

        // A FIFO full for 5 cycles.
        a0 = a_wr_cnt;
        b0 = b_wr_cnt;
        bus.a_full_n = 1'b0;
        send_group(quad(5, 6, 7, 8), quad(1, 1, 1, 1));
        check("t2_b_write_entry", 64'(bus.b_write), 64'(1));
        check("t2_a_write_entry", 64'(bus.a_write), 64'(0));
        for (int k = 1; k < 5; k++) begin
            step();
            check("t2_a_held", 64'(bus.a_write), 64'(0));
            check("t2_b_no_dup", 64'(bus.b_write), 64'(0));
            check("t2_a_dout_stable", 64'(bus.a_dout), 64'h1001C03005);
        end
        bus.a_full_n = 1'b1;
        #1;
        check("t2_a_write", 64'(bus.a_write), 64'(1));
        step();
        check("t2_a_once", 64'(bus.a_write), 64'(0));
        check("t2_blk_start", 64'(bus.blk_start), 64'(1));
        drain4(quad(6, 7, 8, 9), 4, 0);
        check("t2_a_writes", 64'(a_wr_cnt - a0), 64'(1));
        check("t2_b_writes", 64'(b_wr_cnt - b0), 64'(1));

        // Lane wrap and result back-pressure.
        send_group(quad(11'h7FF, 11'h100, 0, 11'h3FF), quad(1, 11'h100, 0, 11'h400));
        drain4(quad(0, 11'h200, 0, 11'h7FF), 1, 3);

        // Clock enable dropped for two cycles while blk_done is up.
        send_group(quad(1, 2, 3, 4), quad(5, 5, 5, 5));
        repeat (3) step();
        check("t4_continue", 64'(bus.blk_continue), 64'(1));
        ap_ce = 1'b0;
        #1;
        check("t4_ce_continue", 64'(bus.blk_continue), 64'(0));
        for (int k = 0; k < 2; k++) begin
            step();
            check("t4_frozen_start", 64'(bus.blk_start), 64'(1));
            check("t4_frozen_rvalid", 64'(bus.r_valid), 64'(0));
        end
        ap_ce = 1'b1;
        #1;
        check("t4_resume_continue", 64'(bus.blk_continue), 64'(1));
        step();
        check("t4_drain", 64'(bus.r_valid), 64'(1));
        drain4(quad(6, 7, 8, 9), 4, 0);

        // Adder never finishes.
        adder_en = 1'b0;
        send_group(quad(9, 9, 9, 9), quad(9, 9, 9, 9));
        check("t5_err_before", 64'(bus.err_timeout), 64'(0));
        step();
        n = 0;
        while (bus.blk_start && n < 400) begin
            n++;
            step();
        end
        check("t5_start_cycles", 64'(n), 64'(TIMEOUT));
        check("t5_err", 64'(bus.err_timeout), 64'(1));
        check("t5_s_ready", 64'(bus.s_ready), 64'(1));
        check("t5_busy", 64'(bus.busy), 64'(0));
        adder_en = 1'b1;

        // Reset in the middle of DRAIN.
        send_group(quad(100, 200, 300, 400), quad(1, 2, 3, 4));
        n = 0;
        while (!bus.r_valid && n < 50) begin
            step();
            n++;
        end
        check("t6_in_drain", 64'(bus.r_valid), 64'(1));
        bus.r_ready = 1'b1;
        step();
        bus.r_ready = 1'b0;
        ap_rst = 1'b1;
        step();
        check("t6_s_ready", 64'(bus.s_ready), 64'(0));
        check("t6_busy", 64'(bus.busy), 64'(0));
        check("t6_r_valid", 64'(bus.r_valid), 64'(0));
        check("t6_r_data", 64'(bus.r_data), 64'(0));
        check("t6_r_last", 64'(bus.r_last), 64'(0));
        check("t6_a_dout", 64'(bus.a_dout), 64'(0));
        check("t6_b_dout", 64'(bus.b_dout), 64'(0));
        check("t6_err", 64'(bus.err_timeout), 64'(0));
        check("t6_blk_start", 64'(bus.blk_start), 64'(0));
        check("t6_blk_continue", 64'(bus.blk_continue), 64'(0));
        check("t6_writes", 64'({bus.a_write, bus.b_write}), 64'(0));
        ap_rst = 1'b0;
        step();
        a0 = a_wr_cnt;
        b0 = b_wr_cnt;
        send_group(quad(1, 2, 3, 4), quad(10, 20, 30, 40));
        check("t6_a_dout_new", 64'(bus.a_dout), 64'h800C01001);
        drain4(quad(11, 22, 33, 44), 4, 0);
        check("t6_a_writes", 64'(a_wr_cnt - a0), 64'(1));
        check("t6_b_writes", 64'(b_wr_cnt - b0), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
